// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter merging ALU results and buffered load returns onto the register file port.
// Define WB_PERF_EN to add the forced-drain and LSU backpressure event counters.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_dest,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     ld_issue_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_issue_dest,
  input  logic                     lsu_valid,
  input  logic [ADDRESS_WIDTH-1:0] lsu_dest,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     lsu_ready,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [NUM_REGS-1:0]      busy_mask
`ifdef WB_PERF_EN
  ,
  output logic [31:0]              perf_drain_cnt,
  output logic [31:0]              perf_lsu_bp_cnt
`endif
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH-1:0] fifo_dest_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_dest_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data_d [FIFO_DEPTH];
  logic [ST_W-1:0]          starve_q, starve_d;
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic                     regwrite_q, regwrite_d;
  logic [ADDRESS_WIDTH-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;

  logic                     fifo_empty, fifo_full, push;
  logic                     alu_win, fifo_win, forced_drain;
  logic [ADDRESS_WIDTH-1:0] head_dest;
  logic [DATA_WIDTH-1:0]    head_data;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                      (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign lsu_ready  = !fifo_full;
  assign push       = lsu_valid && !fifo_full;
  assign head_dest  = fifo_dest_q[rd_ptr_q[IDX_W-1:0]];
  assign head_data  = fifo_data_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    alu_win      = 1'b0;
    fifo_win     = 1'b0;
    forced_drain = 1'b0;
    alu_ready    = 1'b1;
    starve_d     = '0;
    if (fifo_empty) begin
      alu_win = alu_valid;
    end else if (alu_valid && (starve_q < STARVE_MAX)) begin
      alu_win  = 1'b1;
      starve_d = starve_q + 1'b1;
    end else begin
      fifo_win     = 1'b1;
      forced_drain = alu_valid;
      alu_ready    = !alu_valid;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_dest_d = fifo_dest_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_dest_d[wr_ptr_q[IDX_W-1:0]] = lsu_dest;
      fifo_data_d[wr_ptr_q[IDX_W-1:0]] = lsu_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_win) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // x0 winners still consume their slot but leave the write port untouched.
  always_comb begin
    regwrite_d = 1'b0;
    wr_dest_d  = wr_dest_q;
    wr_data_d  = wr_data_q;
    if (alu_win && (alu_dest != '0)) begin
      regwrite_d = 1'b1;
      wr_dest_d  = alu_dest;
      wr_data_d  = alu_data;
    end else if (fifo_win && (head_dest != '0)) begin
      regwrite_d = 1'b1;
      wr_dest_d  = head_dest;
      wr_data_d  = head_data;
    end
  end

  // Set is applied after clear so a fresh issue wins over a same-cycle return.
  always_comb begin
    busy_d = busy_q;
    if (fifo_win) begin
      busy_d[head_dest] = 1'b0;
    end
    if (ld_issue_valid && (ld_issue_dest != '0)) begin
      busy_d[ld_issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
      regwrite_q <= 1'b0;
      wr_dest_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      regwrite_q <= regwrite_d;
      wr_dest_q  <= wr_dest_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_dest_q <= fifo_dest_d;
    fifo_data_q <= fifo_data_d;
  end

  assign RegWrite    = regwrite_q;
  assign rg_wrt_dest = wr_dest_q;
  assign rg_wrt_data = wr_data_q;
  assign busy_mask   = busy_q;

`ifdef WB_PERF_EN
  logic [31:0] drain_cnt_q, drain_cnt_d, bp_cnt_q, bp_cnt_d;

  always_comb begin
    drain_cnt_d = drain_cnt_q;
    bp_cnt_d    = bp_cnt_q;
    if (forced_drain && (drain_cnt_q != '1)) begin
      drain_cnt_d = drain_cnt_q + 1'b1;
    end
    if (lsu_valid && fifo_full && (bp_cnt_q != '1)) begin
      bp_cnt_d = bp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_q <= '0;
      bp_cnt_q    <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      bp_cnt_q    <= bp_cnt_d;
    end
  end

  assign perf_drain_cnt  = drain_cnt_q;
  assign perf_lsu_bp_cnt = bp_cnt_q;
`else
  logic unused_drain;
  assign unused_drain = forced_drain;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter.
// Each vector: inputs driven at negedge, outputs checked 1ns later (registered outputs reflect the previous edge).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_dest;
  logic        lsu_valid;
  logic [4:0]  lsu_dest;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        RegWrite;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  logic [31:0] busy_mask;
`ifdef WB_PERF_EN
  logic [31:0] perf_drain_cnt;
  logic [31:0] perf_lsu_bp_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_dest(ld_issue_dest),
    .lsu_valid(lsu_valid), .lsu_dest(lsu_dest), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .busy_mask(busy_mask)
`ifdef WB_PERF_EN
    ,
    .perf_drain_cnt(perf_drain_cnt), .perf_lsu_bp_cnt(perf_lsu_bp_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        iv;
    logic [4:0]  id;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldat;
    logic        e_rw;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    logic        e_ar;
    logic        e_lr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ad, input logic [31:0] adat,
                              input logic iv, input logic [4:0] id,
                              input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                              input logic rw, input logic [4:0] ed, input logic [31:0] edat,
                              input logic [31:0] eb, input logic ar, input logic lr);
    vec_t v;
    v.rst = r; v.av = av; v.ad = ad; v.adat = adat; v.iv = iv; v.id = id;
    v.lv = lv; v.ld = ld; v.ldat = ldat;
    v.e_rw = rw; v.e_dest = ed; v.e_data = edat; v.e_busy = eb; v.e_ar = ar; v.e_lr = lr;
    return v;
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%h expected=%h", tag, what, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst = v.rst;
    alu_valid = v.av; alu_dest = v.ad; alu_data = v.adat;
    ld_issue_valid = v.iv; ld_issue_dest = v.id;
    lsu_valid = v.lv; lsu_dest = v.ld; lsu_data = v.ldat;
    #1;
    chk(tag, "RegWrite",    {31'd0, RegWrite},   {31'd0, v.e_rw});
    chk(tag, "rg_wrt_dest", {27'd0, rg_wrt_dest}, {27'd0, v.e_dest});
    chk(tag, "rg_wrt_data", rg_wrt_data,          v.e_data);
    chk(tag, "busy_mask",   busy_mask,            v.e_busy);
    chk(tag, "alu_ready",   {31'd0, alu_ready},  {31'd0, v.e_ar});
    chk(tag, "lsu_ready",   {31'd0, lsu_ready},  {31'd0, v.e_lr});
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   1, 1);
    tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,            0, 0, 0,            32'h0,   1, 1);
    tbl[2]  = mk(0, 0, 0, 0,            1, 7, 0, 0, 0,            1, 5, 32'hDEADBEEF, 32'h0,   1, 1);
    tbl[3]  = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 5, 32'hDEADBEEF, 32'h80,  1, 1);
    tbl[4]  = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 5, 32'hDEADBEEF, 32'h80,  1, 1);
    tbl[5]  = mk(0, 0, 0, 0,            0, 0, 1, 7, 32'h12345678, 0, 5, 32'hDEADBEEF, 32'h80,  1, 1);
    tbl[6]  = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 5, 32'hDEADBEEF, 32'h80,  1, 1);
    tbl[7]  = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 7, 32'h12345678, 32'h0,   1, 1);
    tbl[8]  = mk(0, 1, 0, 32'hAAAA,     1, 0, 0, 0, 0,            0, 7, 32'h12345678, 32'h0,   1, 1);
    tbl[9]  = mk(0, 0, 0, 0,            1, 9, 1, 0, 32'h5555,     0, 7, 32'h12345678, 32'h0,   1, 1);
    tbl[10] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 7, 32'h12345678, 32'h200, 1, 1);
    tbl[11] = mk(0, 0, 0, 0,            0, 0, 1, 9, 32'h99,       0, 7, 32'h12345678, 32'h200, 1, 1);
    tbl[12] = mk(0, 0, 0, 0,            1, 9, 0, 0, 0,            0, 7, 32'h12345678, 32'h200, 1, 1);
    tbl[13] = mk(0, 0, 0, 0,            0, 0, 1, 9, 32'hABCD,     1, 9, 32'h99,       32'h200, 1, 1);
    tbl[14] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 9, 32'h99,       32'h200, 1, 1);
    tbl[15] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            1, 9, 32'hABCD,     32'h0,   1, 1);
    tbl[16] = mk(0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 9, 32'hABCD,     32'h0,   1, 1);

    rst = 1'b1;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_dest = 0;
    lsu_valid = 0; lsu_dest = 0; lsu_data = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) apply($sformatf("basic%0d", i), tbl[i]);

    // Starvation: one queued load loses three times, then a single forced drain.
    apply("starve0", mk(0, 0, 0, 0,        1, 12, 0, 0, 0,             0, 9, 32'hABCD,  32'h0,    1, 1));
    apply("starve1", mk(0, 1, 1, 32'h101,  0, 0,  1, 12, 32'hC0C0,     0, 9, 32'hABCD,  32'h1000, 1, 1));
    apply("starve2", mk(0, 1, 2, 32'h102,  0, 0,  0, 0, 0,             1, 1, 32'h101,   32'h1000, 1, 1));
    apply("starve3", mk(0, 1, 3, 32'h103,  0, 0,  0, 0, 0,             1, 2, 32'h102,   32'h1000, 1, 1));
    apply("starve4", mk(0, 1, 4, 32'h104,  0, 0,  0, 0, 0,             1, 3, 32'h103,   32'h1000, 1, 1));
    apply("starve5", mk(0, 1, 5, 32'h105,  0, 0,  0, 0, 0,             1, 4, 32'h104,   32'h1000, 0, 1));
    apply("starve6", mk(0, 1, 5, 32'h105,  0, 0,  0, 0, 0,             1, 12, 32'hC0C0, 32'h0,    1, 1));
    apply("starve7", mk(0, 0, 0, 0,        0, 0,  0, 0, 0,             1, 5, 32'h105,   32'h0,    1, 1));
    apply("starve8", mk(0, 0, 0, 0,        0, 0,  0, 0, 0,             0, 5, 32'h105,   32'h0,    1, 1));

    // Five back-to-back returns into a 4-deep FIFO while the ALU stays busy.
    apply("full0",  mk(0, 1, 1, 32'hA001, 0, 0, 1, 25, 32'hB001, 0, 5,  32'h105,  32'h0, 1, 1));
    apply("full1",  mk(0, 1, 2, 32'hA002, 0, 0, 1, 26, 32'hB002, 1, 1,  32'hA001, 32'h0, 1, 1));
    apply("full2",  mk(0, 1, 3, 32'hA003, 0, 0, 1, 27, 32'hB003, 1, 2,  32'hA002, 32'h0, 1, 1));
    apply("full3",  mk(0, 1, 4, 32'hA004, 0, 0, 1, 28, 32'hB004, 1, 3,  32'hA003, 32'h0, 1, 1));
    apply("full4",  mk(0, 1, 5, 32'hA005, 0, 0, 1, 29, 32'hB005, 1, 4,  32'hA004, 32'h0, 0, 0));
    apply("full5",  mk(0, 1, 5, 32'hA005, 0, 0, 1, 29, 32'hB005, 1, 25, 32'hB001, 32'h0, 1, 1));
    apply("full6",  mk(0, 0, 0, 0,        0, 0, 0, 0, 0,         1, 5,  32'hA005, 32'h0, 1, 0));
    apply("full7",  mk(0, 0, 0, 0,        0, 0, 0, 0, 0,         1, 26, 32'hB002, 32'h0, 1, 1));
    apply("full8",  mk(0, 0, 0, 0,        0, 0, 0, 0, 0,         1, 27, 32'hB003, 32'h0, 1, 1));
    apply("full9",  mk(0, 0, 0, 0,        0, 0, 0, 0, 0,         1, 28, 32'hB004, 32'h0, 1, 1));
    apply("full10", mk(0, 0, 0, 0,        0, 0, 0, 0, 0,         1, 29, 32'hB005, 32'h0, 1, 1));
    apply("full11", mk(0, 0, 0, 0,        0, 0, 0, 0, 0,         0, 29, 32'hB005, 32'h0, 1, 1));

    // Reset with two queued loads and busy_mask = 0xA0.
    apply("rst0", mk(0, 0, 0, 0,     1, 5, 0, 0, 0,     0, 29, 32'hB005, 32'h0,  1, 1));
    apply("rst1", mk(0, 0, 0, 0,     1, 7, 0, 0, 0,     0, 29, 32'hB005, 32'h20, 1, 1));
    apply("rst2", mk(0, 1, 1, 32'hE1, 0, 0, 1, 5, 32'hD5, 0, 29, 32'hB005, 32'hA0, 1, 1));
    apply("rst3", mk(0, 1, 2, 32'hE2, 0, 0, 1, 7, 32'hD7, 1, 1,  32'hE1,   32'hA0, 1, 1));
    apply("rst4", mk(1, 0, 0, 0,     0, 0, 0, 0, 0,     1, 2,  32'hE2,   32'hA0, 1, 1));
    apply("rst5", mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0,  32'h0,    32'h0,  1, 1));
    apply("rst6", mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0,  32'h0,    32'h0,  1, 1));
    apply("rst7", mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0,  32'h0,    32'h0,  1, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
